// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : disp_pkg
//  Description : Shared definitions for the 7-segment display scanner.
//                It holds the scan FSM state encoding, the logical digit-select
//                levels and the BCD nibble width.
//  Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Width of one packed BCD digit.
    localparam int BCD_W = 4;

    // Digit-select levels before pin polarity is applied (logical on/off).
    localparam logic SEL_ON  = 1'b1;
    localparam logic SEL_OFF = 1'b0;

    // Scan FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

endpackage : disp_pkg
`default_nettype wire

// File: rtl/disp_lz_mask.sv
`default_nettype none
// ============================================================================
//  Module      : disp_lz_mask
//  Description : Combinational leading-zero blank mask for a packed BCD word.
//                Digit k is flagged when blanking is enabled, nibbles 0..k
//                (counting from the most significant nibble) are all zero, and
//                k is not the last digit.
//  Ports       : in_bcd   - packed BCD, digit 0 = most significant nibble
//                lz_en    - leading-zero blanking enable
//                out_mask - bit k = 1 -> digit k is blanked
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_lz_mask
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [BCD_W*NUM_DIGITS-1:0] in_bcd,
    input  logic                        lz_en,
    output logic [NUM_DIGITS-1:0]       out_mask
);

    // zero_run[k+1] = nibbles 0..k are all zero.
    logic [NUM_DIGITS:0] zero_run;

    assign zero_run[0] = 1'b1;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_mask
        assign zero_run[k+1] = zero_run[k] &
                               (in_bcd[BCD_W*(NUM_DIGITS-1-k) +: BCD_W] == '0);
        if (k == NUM_DIGITS - 1) begin : g_last
            // The last digit always shows, so a value of zero still reads "0".
            assign out_mask[k] = 1'b0;
        end else begin : g_lead
            assign out_mask[k] = lz_en & zero_run[k+1];
        end
    end

endmodule : disp_lz_mask
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : disp_scan_ctrl
//  Description : Time-multiplexed scanner for N-digit common-anode 7-segment
//                displays. A snapshot of the BCD word, decimal points and
//                leading-zero mask is taken once per frame. Each digit slot is
//                DIV cycles: BLANK_CYCLES dead cycles with all selects off,
//                then the digit is shown for the rest of the slot.
//  Ports       : clk, resetn        - clock, async active-low reset
//                en                 - scan enable (low = dark, restart on rise)
//                in_bcd, dp_in      - display value and decimal points
//                lz_blank_en        - leading-zero blanking enable
//                out_bcd, out_dp    - nibble / dp of the active digit
//                out_blank          - decoder must turn all segments off
//                out_sel            - one-hot digit select (polarity param)
//                frame_start        - one-cycle pulse at each frame start
//  Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DIV            = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        en,
    input  logic [BCD_W*NUM_DIGITS-1:0] in_bcd,
    input  logic [NUM_DIGITS-1:0]       dp_in,
    input  logic                        lz_blank_en,
    output logic [BCD_W-1:0]            out_bcd,
    output logic                        out_dp,
    output logic                        out_blank,
    output logic [NUM_DIGITS-1:0]       out_sel,
    output logic                        frame_start
);

    localparam int CNT_W = $clog2(DIV);
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic             HAS_BLANK  = (BLANK_CYCLES > 0);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV - BLANK_CYCLES - 1);
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);

    // Pin level that corresponds to a deselected digit.
    localparam logic             SEL_POL    = (SEL_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE_PINS = {NUM_DIGITS{SEL_OFF ^ SEL_POL}};

    scan_state_t                 state_q, state_d;
    logic [CNT_W-1:0]            slot_q, slot_d;
    logic [DIG_W-1:0]            digit_q, digit_d;
    logic [BCD_W*NUM_DIGITS-1:0] snap_bcd_q, snap_bcd_d;
    logic [NUM_DIGITS-1:0]       snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]       snap_lz_q, snap_lz_d;

    logic [BCD_W-1:0]            out_bcd_q, out_bcd_d;
    logic                        out_dp_q, out_dp_d;
    logic                        out_blank_q, out_blank_d;
    logic [NUM_DIGITS-1:0]       out_sel_q, out_sel_d;
    logic                        frame_start_q, frame_start_d;

    logic [NUM_DIGITS-1:0]       lz_mask;
    logic [NUM_DIGITS-1:0]       sel_raw;
    logic                        load_frame;

    disp_lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .in_bcd   (in_bcd),
        .lz_en    (lz_blank_en),
        .out_mask (lz_mask)
    );

    // Next-state, counters and snapshot.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        digit_d    = digit_q;
        snap_bcd_d = snap_bcd_q;
        snap_dp_d  = snap_dp_q;
        snap_lz_d  = snap_lz_q;
        load_frame = 1'b0;

        if (!en) begin
            state_d = ST_IDLE;
            slot_d  = '0;
            digit_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    load_frame = 1'b1;
                    digit_d    = '0;
                    slot_d     = '0;
                    state_d    = HAS_BLANK ? ST_BLANK : ST_SHOW;
                end
                ST_BLANK: begin
                    if (slot_q == BLANK_LAST) begin
                        slot_d  = '0;
                        state_d = ST_SHOW;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (slot_q == SHOW_LAST) begin
                        slot_d  = '0;
                        state_d = HAS_BLANK ? ST_BLANK : ST_SHOW;
                        if (digit_q == LAST_DIGIT) begin
                            digit_d    = '0;
                            load_frame = 1'b1;
                        end else begin
                            digit_d = digit_q + 1'b1;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    slot_d  = '0;
                    digit_d = '0;
                end
            endcase
        end

        if (load_frame) begin
            snap_bcd_d = in_bcd;
            snap_dp_d  = dp_in;
            snap_lz_d  = lz_mask;
        end
    end

    // Output values are derived from the *next* state and snapshot so that
    // they are registered on the same edge the state changes, including the
    // frame wrap where a fresh snapshot is shown immediately.
    always_comb begin
        sel_raw       = {NUM_DIGITS{SEL_OFF}};
        out_bcd_d     = '0;
        out_dp_d      = 1'b0;
        out_blank_d   = 1'b1;
        frame_start_d = load_frame;

        if (state_d == ST_SHOW) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (digit_d == DIG_W'(k)) begin
                    sel_raw[k]  = SEL_ON;
                    out_bcd_d   = snap_bcd_d[BCD_W*(NUM_DIGITS-1-k) +: BCD_W];
                    out_dp_d    = snap_dp_d[k];
                    out_blank_d = snap_lz_d[k];
                end
            end
        end

        out_sel_d = sel_raw ^ {NUM_DIGITS{SEL_POL}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            slot_q        <= '0;
            digit_q       <= '0;
            snap_bcd_q    <= '0;
            snap_dp_q     <= '0;
            snap_lz_q     <= '0;
            out_bcd_q     <= '0;
            out_dp_q      <= 1'b0;
            out_blank_q   <= 1'b1;
            out_sel_q     <= SEL_IDLE_PINS;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            digit_q       <= digit_d;
            snap_bcd_q    <= snap_bcd_d;
            snap_dp_q     <= snap_dp_d;
            snap_lz_q     <= snap_lz_d;
            out_bcd_q     <= out_bcd_d;
            out_dp_q      <= out_dp_d;
            out_blank_q   <= out_blank_d;
            out_sel_q     <= out_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign out_bcd     = out_bcd_q;
    assign out_dp      = out_dp_q;
    assign out_blank   = out_blank_q;
    assign out_sel     = out_sel_q;
    assign frame_start = frame_start_q;

endmodule : disp_scan_ctrl
`default_nettype wire
